// File: rtl/data_mem_initiator.sv
// data_mem_initiator: MEM-stage initiator for a multi-cycle, word-addressed
// data memory. Converts byte addresses to word indices, runs a fixed-latency
// access, captures load data, and stalls the pipeline via freeze until the
// access has retired. Illegal requests are rejected with a memErr pulse and
// never reach the memory.
//
// Handshake: the pipeline presents a request by holding memRead or memWrite
// (the "valid") together with address/writeData. The request is accepted in
// the IDLE cycle in which it is seen. freeze is the inverse of "ready". It
// stays high from the accepting IDLE cycle through the last ACCESS cycle.
// The pipeline must hold its request stable while freeze is high. The
// pipeline advances on the DONE edge, where freeze is low. Any request
// visible in DONE belongs to the retiring instruction and is not accepted.
module data_mem_initiator #(
  parameter int BASE_ADDR      = 1024,
  parameter int ACCESS_LATENCY = 4,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [31:0]       address,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              freeze,
  output logic              memErr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(ACCESS_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;

  // Request decode and legality
  logic        req;
  logic [31:0] word_full;
  logic        misaligned;
  logic        below_base;
  logic        above_top;
  logic        both_ops;
  logic        illegal;
  logic        start;
  logic        reject;
  logic        last_cycle;

  // Byte offset from the base, turned into a full-width word index. Only the
  // low ADDR_W bits go to the memory. Any higher set bit means the word
  // lies past the top of the memory.
  assign req        = memRead | memWrite;
  assign word_full  = (address - 32'(BASE_ADDR)) >> 2;
  assign misaligned = (address[1:0] != 2'b00);
  assign below_base = (address < 32'(BASE_ADDR));
  assign above_top  = ((word_full >> ADDR_W) != 32'd0);
  assign both_ops   = memRead & memWrite;
  assign illegal    = misaligned | below_base | above_top | both_ops;
  assign last_cycle = (state_q == ACCESS) && (cnt == '0);

  assign state_dbg  = state_q;

  // Next-state, freeze and request-acceptance decode
  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    start   = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            reject = 1'b1;
          end else begin
            start   = 1'b1;
            freeze  = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        freeze = 1'b1;
        if (cnt == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // While reset is active the FSM is held in IDLE. A request may still be
    // on the inputs at that time, so the stall is forced off explicitly.
    if (rst) begin
      freeze = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Error pulse: one cycle after a rejected IDLE request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memErr <= 1'b0;
    end else begin
      memErr <= reject;
    end
  end

  // Memory-side request registers: loaded on acceptance and held for the
  // whole access. Strobes drop on the last access edge. Reset abandons an
  // access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_rd    <= memRead;
      mem_wr    <= memWrite;
      mem_addr  <= word_full[ADDR_W-1:0];
      mem_wdata <= writeData;
    end else if (last_cycle) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end
  end

  // Latency down-counter: reaches zero in the final ACCESS cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_INIT;
    end else if ((state_q == ACCESS) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Load data capture: memory data is valid on the last access cycle. The
  // result is held until the next completed load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData <= '0;
    end else if (last_cycle && mem_rd) begin
      readData <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_initiator.sv
// tb_data_mem_initiator: directed bench for data_mem_initiator with
// ACCESS_LATENCY=4 (main instance) and ACCESS_LATENCY=1 (second instance).
module tb_data_mem_initiator;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (latency 4)
  logic        memRead, memWrite;
  logic [31:0] address, writeData, readData, mem_wdata, mem_rdata;
  logic        freeze, memErr, mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [1:0]  state_dbg;

  // Second instance (latency 1)
  logic        memRead1, memWrite1;
  logic [31:0] readData1, mem_wdata1;
  logic [31:0] mem_rdata1;
  logic        freeze1, memErr1, mem_rd1, mem_wr1;
  logic [15:0] mem_addr1;
  logic [1:0]  state_dbg1;

  assign mem_rdata1 = 32'h1234_5678;

  data_mem_initiator #(.BASE_ADDR(1024), .ACCESS_LATENCY(4), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .readData(readData),
    .freeze(freeze), .memErr(memErr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  data_mem_initiator #(.BASE_ADDR(1024), .ACCESS_LATENCY(1), .ADDR_W(16)) dut1 (
    .clk(clk), .rst(rst), .memRead(memRead1), .memWrite(memWrite1),
    .address(address), .writeData(writeData), .readData(readData1),
    .freeze(freeze1), .memErr(memErr1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .state_dbg(state_dbg1)
  );

  // Small memory model: 16 words indexed by the low index bits
  logic [31:0] mem_model [16];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) mem_model[k] <= 32'hC0DE_0000 + 32'(k);
    end else if (mem_wr) begin
      mem_model[mem_addr[3:0]] <= mem_wdata;
    end
  end

  always_comb mem_rdata = mem_model[mem_addr[3:0]];

  // Scoreboard counters
  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one request, hold it while frozen, drop it after DONE.
  // Samples 10 cycles and reports freeze, strobe and error cycle counts.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int frz, output int stb,
                        output int err, output logic [15:0] seen);
    logic drop;
    frz = 0; stb = 0; err = 0; seen = '0; drop = 1'b0;
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; address = a; writeData = d;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (drop) begin memRead = 1'b0; memWrite = 1'b0; end
        #1;
      end
      if (freeze) frz++;
      if (mem_rd | mem_wr) begin stb++; seen = mem_addr; end
      if (memErr) err++;
      drop = !freeze;
    end
  endtask

  int          frz, stb, err;
  logic [15:0] seen;
  int          rises, highs, lows;
  logic        prev_rd;

  initial begin
    rst = 1'b1;
    memRead = 0; memWrite = 0; address = 0; writeData = 0;
    memRead1 = 0; memWrite1 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_state",    32'(state_dbg), 32'd0);
    check("rst_freeze",   32'(freeze),    32'd0);
    check("rst_readdata", readData,       32'd0);
    check("rst_memerr",   32'(memErr),    32'd0);
    check("rst_strobes",  32'({mem_rd, mem_wr}), 32'd0);
    check("rst_addr",     32'(mem_addr),  32'd0);
    @(negedge clk) rst = 1'b0;

    // Reset in the middle of a write access
    @(posedge clk); #1;
    memWrite = 1; address = 32'h40C; writeData = 32'h1111_2222;
    #1;
    check("rstw_freeze_req", 32'(freeze), 32'd1);
    @(posedge clk); #2;
    check("rstw_wr_high", 32'(mem_wr),   32'd1);
    check("rstw_addr",    32'(mem_addr), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("rstw_wr_drop",  32'(mem_wr), 32'd0);
    check("rstw_freeze0",  32'(freeze), 32'd0);
    memWrite = 0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
    check("rstw_state",    32'(state_dbg), 32'd0);
    check("rstw_freeze",   32'(freeze),    32'd0);
    check("rstw_readdata", readData,       32'd0);
    check("rstw_memerr",   32'(memErr),    32'd0);

    // Store 0xDEADBEEF at 0x408
    access(1'b0, 1'b1, 32'h408, 32'hDEAD_BEEF, frz, stb, err, seen);
    check("st_freeze_cycles", 32'(frz),  32'd5);
    check("st_wr_cycles",     32'(stb),  32'd4);
    check("st_addr",          32'(seen), 32'd2);
    check("st_err",           32'(err),  32'd0);
    check("st_readdata_kept", readData,  32'd0);
    check("st_mem_word",      mem_model[2], 32'hDEAD_BEEF);

    // Load it back
    access(1'b1, 1'b0, 32'h408, 32'h0, frz, stb, err, seen);
    check("ld_freeze_cycles", 32'(frz),  32'd5);
    check("ld_rd_cycles",     32'(stb),  32'd4);
    check("ld_addr",          32'(seen), 32'd2);
    check("ld_data",          readData,  32'hDEAD_BEEF);

    // Base boundary: 0x400 is word 0
    access(1'b1, 1'b0, 32'h400, 32'h0, frz, stb, err, seen);
    check("base_addr", 32'(seen), 32'd0);
    check("base_data", readData,  32'hC0DE_0000);

    // Just below base
    access(1'b1, 1'b0, 32'h3FC, 32'h0, frz, stb, err, seen);
    check("below_err",    32'(err), 32'd1);
    check("below_strobe", 32'(stb), 32'd0);
    check("below_freeze", 32'(frz), 32'd0);
    check("below_data",   readData, 32'hC0DE_0000);

    // Misaligned store, then confirm word 0 untouched
    access(1'b0, 1'b1, 32'h402, 32'hBAD0_BAD0, frz, stb, err, seen);
    check("mis_err",    32'(err), 32'd1);
    check("mis_strobe", 32'(stb), 32'd0);
    check("mis_freeze", 32'(frz), 32'd0);
    access(1'b1, 1'b0, 32'h400, 32'h0, frz, stb, err, seen);
    check("mis_prior_data", readData, 32'hC0DE_0000);

    // Both strobes at once
    access(1'b1, 1'b1, 32'h400, 32'h5555_5555, frz, stb, err, seen);
    check("both_err",    32'(err), 32'd1);
    check("both_strobe", 32'(stb), 32'd0);

    // Top boundary: last legal word and first illegal one
    access(1'b1, 1'b0, 32'h0004_03FC, 32'h0, frz, stb, err, seen);
    check("top_addr",   32'(seen), 32'h0000_FFFF);
    check("top_err",    32'(err),  32'd0);
    check("top_freeze", 32'(frz),  32'd5);
    check("top_data",   readData,  32'hC0DE_000F);
    access(1'b1, 1'b0, 32'h0004_0400, 32'h0, frz, stb, err, seen);
    check("over_err",    32'(err), 32'd1);
    check("over_strobe", 32'(stb), 32'd0);

    // Back-to-back loads held through freeze
    rises = 0; highs = 0; lows = 0; prev_rd = 1'b0;
    @(posedge clk); #1;
    memRead = 1; address = 32'h408;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      if (!freeze) lows++;
      if (mem_rd) highs++;
      if (mem_rd && !prev_rd) rises++;
      prev_rd = mem_rd;
    end
    @(posedge clk); #1;
    memRead = 0;
    check("b2b_rd_rises",   32'(rises), 32'd2);
    check("b2b_rd_cycles",  32'(highs), 32'd8);
    check("b2b_freeze_low", 32'(lows),  32'd2);
    check("b2b_data",       readData,   32'hDEAD_BEEF);
    repeat (3) @(posedge clk);

    // Latency 1 instance: two-cycle freeze, one strobe cycle
    frz = 0; stb = 0;
    @(posedge clk); #1;
    memRead1 = 1; address = 32'h404;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (!prev_rd) memRead1 = 0;
        #1;
      end
      if (freeze1) frz++;
      if (mem_rd1) begin stb++; seen = mem_addr1; end
      prev_rd = freeze1;
    end
    check("l1_freeze_cycles", 32'(frz),  32'd2);
    check("l1_rd_cycles",     32'(stb),  32'd1);
    check("l1_addr",          32'(seen), 32'd1);
    check("l1_data",          readData1, 32'h1234_5678);
    @(posedge clk); #2;
    check("l1_idle", 32'(state_dbg1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_initiator.md
Name: data_mem_initiator

Overview:
- Initiator side of the data-memory interface. Sits in the MEM stage of the ARM pipeline, between the stage's memRead/memWrite request and a multi-cycle word-addressed data memory.
- Translates byte addresses into word indices, sequences a fixed-latency access and captures read data.
- Holds freeze high so the pipeline stalls until the access completes.
- Rejects illegal addresses without touching memory.

Parameters:
- BASE_ADDR, 1024: byte address of memory word 0.
- ACCESS_LATENCY, 4: cycles the memory needs per access. Legal range is ≥1.
- ADDR_W, 16: width of the word index driven to memory.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active high
- memRead  input  1  pipeline load request, level, held while frozen
- memWrite  input  1  pipeline store request, level, held while frozen
- address  input  32  byte address from ALU result
- writeData  input  32  store data
- readData  output  32  load result, valid in DONE and held afterwards
- freeze  output  1  pipeline stall request
- memErr  output  1  one-cycle pulse on a rejected request
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- mem_addr  output  ADDR_W  word index = (address − BASE_ADDR) >> 2
- mem_wdata  output  32  write data to memory
- mem_rdata  input  32  read data from memory, valid on the last access cycle

Behaviour:
- States: IDLE, ACCESS, DONE. A down-counter cnt has width clog2(ACCESS_LATENCY)+1.
- Reset (async, any state): go to IDLE. Set readData, mem_addr, mem_wdata, cnt to 0. Set mem_rd, mem_wr, memErr to 0. freeze is 0.
- Request legality, evaluated in IDLE:
  - Request exists when memRead|memWrite.
  - Illegal if any of: address[1:0]≠0; address<BASE_ADDR; (address−BASE_ADDR)>>2 ≥ 2^ADDR_W; memRead&memWrite both high.
- IDLE:
  - Legal request: freeze=1 combinationally in the same cycle. At the clock edge:
    - latch mem_addr and mem_wdata=writeData;
    - set mem_rd=memRead, mem_wr=memWrite;
    - set cnt=ACCESS_LATENCY−1;
    - go to ACCESS.
  - Illegal request: freeze=0, no strobe. memErr=1 for exactly the next cycle. Stay in IDLE. readData is unchanged.
  - No request: freeze=0.
- ACCESS:
  - freeze=1. mem_rd/mem_wr/mem_addr/mem_wdata are stable for exactly ACCESS_LATENCY cycles.
  - If cnt≠0: decrement cnt.
  - If cnt=0: at the edge, if mem_rd then readData←mem_rdata. Clear mem_rd and mem_wr. Go to DONE.
  - Pipeline inputs are ignored in this state.
- DONE:
  - freeze=0 for one cycle, so the pipeline advances at this edge. Go to IDLE.
  - Any request seen in DONE belongs to the retiring instruction and is ignored.
- Timing:
  - freeze is high for ACCESS_LATENCY+1 consecutive cycles per legal access.
  - Back-to-back memory ops: the next request is sampled in the IDLE cycle after DONE.
- Write: memory updates on the last ACCESS edge. readData is not modified.
- Reset mid-ACCESS: strobes drop asynchronously, the access is abandoned and no readData update occurs.
- ACCESS_LATENCY=1: ACCESS lasts one cycle. Total freeze is 2 cycles.

Test Plan:
- Reset: assert rst mid-ACCESS of a write -> mem_wr drops immediately. After release: state IDLE, freeze=0, readData=0, memErr=0.
- Store then load, LATENCY=4:
  - memWrite, address=0x408, writeData=0xDEADBEEF -> mem_addr=2, mem_wr high 4 cycles, freeze high 5 cycles then low 1.
  - memRead at 0x408 -> readData=0xDEADBEEF in DONE.
- Base boundary: read at address=0x400 -> mem_addr=0. Read at 0x3FC -> memErr pulse, no mem_rd, freeze never high.
- Misaligned: memWrite at 0x402 -> memErr=1 one cycle, mem_wr never asserted, a following read of 0x400 returns the prior value.
- Both strobes high, address=0x400 -> memErr pulse, no memory strobe.
- Top boundary, ADDR_W=16: 0x400+4·65535 -> mem_addr=0xFFFF, legal. 0x400+4·65536 -> memErr.
- Back-to-back: consecutive loads held through freeze -> each issues one access. DONE cycles have freeze=0, no duplicate access. LATENCY=1 gives freeze of 2 cycles.
